// File: rtl/wb_pkg.sv
// Shared encodings for the registered write-back stage: source selects,
// FSM states and default datapath sizes.
package wb_pkg;

  localparam int WB_WIDTH = 32;
  localparam int WB_AW    = 5;

  typedef enum logic [1:0] {
    MD_F    = 2'b00,
    MD_DOUT = 2'b01,
    MD_STAT = 2'b10,
    MD_MUL  = 2'b11
  } md_e;

  typedef enum logic [1:0] {
    WB_IDLE = 2'b00,
    WB_WR   = 2'b01,
    WB_HI   = 2'b10
  } wb_state_e;

endpackage

// File: rtl/wb_src_mux.sv
// Four-way write-data source select; the SLT flag is zero-padded into bit 0.
module wb_src_mux
  import wb_pkg::*;
#(
  parameter int WIDTH = WB_WIDTH
) (
  input  logic [1:0]       md,
  input  logic [WIDTH-1:0] f,
  input  logic [WIDTH-1:0] data_out,
  input  logic             vxorn,
  input  logic [WIDTH-1:0] mul_lo,
  output logic [WIDTH-1:0] sel_data
);

  // Select the low-half write data for the incoming bundle.
  always_comb begin
    sel_data = {WIDTH{1'b0}};
    case (md)
      MD_F:    sel_data = f;
      MD_DOUT: sel_data = data_out;
      MD_STAT: sel_data = {{(WIDTH-1){1'b0}}, vxorn};
      MD_MUL:  sel_data = mul_lo;
      default: sel_data = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/wb_seq_stage.sv
// Registered write-back stage: one write per accepted bundle, plus an optional
// second cycle that writes the high half of a product to DA+1.
module wb_seq_stage
  import wb_pkg::*;
#(
  parameter int WIDTH    = WB_WIDTH,
  parameter int AW       = WB_AW,
  parameter bit PAIR_MUL = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               rw,
  input  logic [1:0]         md,
  input  logic [AW-1:0]      da,
  input  logic [WIDTH-1:0]   f,
  input  logic [WIDTH-1:0]   data_out,
  input  logic               vxorn,
  input  logic [2*WIDTH-1:0] f_mul,
  output logic               rf_we,
  output logic [AW-1:0]      rf_wa,
  output logic [WIDTH-1:0]   rf_wd,
  output logic               busy_hi
);

  localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  wb_state_e          state_r;
  wb_state_e          state_nxt_s;
  logic               accept_s;
  logic               pair_s;
  logic               pair_r;
  logic [AW-1:0]      da_r;
  logic [AW-1:0]      da_hi_s;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   sel_data_s;
  logic               rf_we_r;
  logic [AW-1:0]      rf_wa_r;
  logic [WIDTH-1:0]   rf_wd_r;
  logic               busy_hi_r;
  logic               in_ready_r;
  logic               rf_we_nxt_s;
  logic [AW-1:0]      rf_wa_nxt_s;
  logic [WIDTH-1:0]   rf_wd_nxt_s;
  logic               busy_hi_nxt_s;
  logic               in_ready_nxt_s;

  function automatic logic we_allowed(input logic [AW-1:0] addr);
    return !(ZERO_REG && (addr == ADDR_ZERO));
  endfunction

  assign accept_s = in_valid && in_ready_r;
  assign pair_s   = PAIR_MUL && rw && (md == MD_MUL);
  assign da_hi_s  = da_r + ADDR_ONE;

  wb_src_mux #(.WIDTH(WIDTH)) u_src_mux (
    .md       (md),
    .f        (f),
    .data_out (data_out),
    .vxorn    (vxorn),
    .mul_lo   (f_mul[WIDTH-1:0]),
    .sel_data (sel_data_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= WB_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a pending high half always wins over a new bundle.
  always_comb begin
    state_nxt_s = WB_IDLE;
    case (state_r)
      WB_IDLE: state_nxt_s = accept_s ? WB_WR : WB_IDLE;
      WB_WR: begin
        if (pair_r) begin
          state_nxt_s = WB_HI;
        end else begin
          state_nxt_s = accept_s ? WB_WR : WB_IDLE;
        end
      end
      WB_HI:   state_nxt_s = accept_s ? WB_WR : WB_IDLE;
      default: state_nxt_s = WB_IDLE;
    endcase
  end

  // Output values for the coming cycle; WR is only ever entered on an accept,
  // so its write comes straight from the incoming bundle.
  always_comb begin
    rf_we_nxt_s    = 1'b0;
    rf_wa_nxt_s    = ADDR_ZERO;
    rf_wd_nxt_s    = {WIDTH{1'b0}};
    busy_hi_nxt_s  = 1'b0;
    in_ready_nxt_s = 1'b1;
    case (state_nxt_s)
      WB_IDLE: begin
        rf_we_nxt_s    = 1'b0;
        in_ready_nxt_s = 1'b1;
      end
      WB_WR: begin
        rf_we_nxt_s    = rw && we_allowed(da);
        rf_wa_nxt_s    = da;
        rf_wd_nxt_s    = sel_data_s;
        busy_hi_nxt_s  = pair_s;
        in_ready_nxt_s = !pair_s;
      end
      WB_HI: begin
        rf_we_nxt_s    = we_allowed(da_hi_s);
        rf_wa_nxt_s    = da_hi_s;
        rf_wd_nxt_s    = hi_r;
        busy_hi_nxt_s  = 1'b1;
        in_ready_nxt_s = 1'b1;
      end
      default: begin
        rf_we_nxt_s    = 1'b0;
        in_ready_nxt_s = 1'b1;
      end
    endcase
  end

  // Bundle fields still needed after the low-half write.
  always_ff @(posedge clk) begin
    if (reset) begin
      pair_r <= 1'b0;
      da_r   <= ADDR_ZERO;
      hi_r   <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      pair_r <= pair_s;
      da_r   <= da;
      hi_r   <= f_mul[2*WIDTH-1:WIDTH];
    end else begin
      pair_r <= pair_r;
      da_r   <= da_r;
      hi_r   <= hi_r;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_r    <= 1'b0;
      rf_wa_r    <= ADDR_ZERO;
      rf_wd_r    <= {WIDTH{1'b0}};
      busy_hi_r  <= 1'b0;
      in_ready_r <= 1'b1;
    end else begin
      rf_we_r    <= rf_we_nxt_s;
      rf_wa_r    <= rf_wa_nxt_s;
      rf_wd_r    <= rf_wd_nxt_s;
      busy_hi_r  <= busy_hi_nxt_s;
      in_ready_r <= in_ready_nxt_s;
    end
  end

  assign rf_we    = rf_we_r;
  assign rf_wa    = rf_wa_r;
  assign rf_wd    = rf_wd_r;
  assign busy_hi  = busy_hi_r;
  assign in_ready = in_ready_r;

endmodule

// File: tb/tb_wb_seq_stage.sv
// Bench for wb_seq_stage: a pair-capable and a single-write instance, checked
// against a per-cycle timeline of expected register-file writes.
module tb_wb_seq_stage;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int N  = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [1:0]     valid;
  logic           rw;
  logic [1:0]     md;
  logic [AW-1:0]  da;
  logic [W-1:0]   f;
  logic [W-1:0]   data_out;
  logic           vxorn;
  logic [2*W-1:0] f_mul;
  logic [1:0]     rdy;
  logic [1:0]     we;
  logic [1:0]     busy;
  logic [AW-1:0]  wa [2];
  logic [W-1:0]   wd [2];

  wb_seq_stage #(.WIDTH(W), .AW(AW), .PAIR_MUL(1'b1), .ZERO_REG(1'b1)) dut_pair (
    .clk(clk), .reset(reset), .in_valid(valid[0]), .in_ready(rdy[0]),
    .rw(rw), .md(md), .da(da), .f(f), .data_out(data_out), .vxorn(vxorn),
    .f_mul(f_mul), .rf_we(we[0]), .rf_wa(wa[0]), .rf_wd(wd[0]), .busy_hi(busy[0])
  );

  wb_seq_stage #(.WIDTH(W), .AW(AW), .PAIR_MUL(1'b0), .ZERO_REG(1'b1)) dut_single (
    .clk(clk), .reset(reset), .in_valid(valid[1]), .in_ready(rdy[1]),
    .rw(rw), .md(md), .da(da), .f(f), .data_out(data_out), .vxorn(vxorn),
    .f_mul(f_mul), .rf_we(we[1]), .rf_wa(wa[1]), .rf_wd(wd[1]), .busy_hi(busy[1])
  );

  // Expected behaviour per instance, indexed by clock-edge number.
  bit          m_slot  [2][N];
  bit          m_we    [2][N];
  bit [AW-1:0] m_wa    [2][N];
  bit [W-1:0]  m_wd    [2][N];
  bit          m_stall [2][N];
  bit          m_busy  [2][N];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  task automatic set_op(input logic r, input logic [1:0] m, input logic [AW-1:0] a,
                        input logic [W-1:0] fv, input logic [W-1:0] dv,
                        input logic vx, input logic [2*W-1:0] fm);
    rw = r; md = m; da = a; f = fv; data_out = dv; vxorn = vx; f_mul = fm;
  endtask

  task automatic schedule(input int i);
    bit pair;
    int hi_addr;
    pair = (i == 0) && rw && (md == 2'b11);
    m_slot[i][cyc] = 1'b1;
    m_we[i][cyc]   = rw && (da != 0);
    m_wa[i][cyc]   = da;
    case (md)
      2'b00:   m_wd[i][cyc] = f;
      2'b01:   m_wd[i][cyc] = data_out;
      2'b10:   m_wd[i][cyc] = vxorn ? 32'd1 : 32'd0;
      default: m_wd[i][cyc] = f_mul[W-1:0];
    endcase
    if (pair) begin
      hi_addr = (int'(da) + 1) % (1 << AW);
      m_stall[i][cyc]  = 1'b1;
      m_busy[i][cyc]   = 1'b1;
      m_slot[i][cyc+1] = 1'b1;
      m_we[i][cyc+1]   = (hi_addr != 0);
      m_wa[i][cyc+1]   = AW'(hi_addr);
      m_wd[i][cyc+1]   = f_mul[2*W-1:W];
      m_busy[i][cyc+1] = 1'b1;
    end
  endtask

  task automatic check_cycle();
    for (int i = 0; i < 2; i++) begin
      checks++;
      assert (we[i] === m_we[i][cyc]) else begin
        errors++;
        $error("FAIL rf_we[%0d] cyc=%0d observed %b expected %b", i, cyc, we[i], m_we[i][cyc]);
      end
      checks++;
      assert (rdy[i] === !m_stall[i][cyc]) else begin
        errors++;
        $error("FAIL in_ready[%0d] cyc=%0d observed %b expected %b", i, cyc, rdy[i], !m_stall[i][cyc]);
      end
      checks++;
      assert (busy[i] === m_busy[i][cyc]) else begin
        errors++;
        $error("FAIL busy_hi[%0d] cyc=%0d observed %b expected %b", i, cyc, busy[i], m_busy[i][cyc]);
      end
      if (m_slot[i][cyc]) begin
        checks++;
        assert (wa[i] === m_wa[i][cyc]) else begin
          errors++;
          $error("FAIL rf_wa[%0d] cyc=%0d observed %0d expected %0d", i, cyc, wa[i], m_wa[i][cyc]);
        end
        checks++;
        assert (wd[i] === m_wd[i][cyc]) else begin
          errors++;
          $error("FAIL rf_wd[%0d] cyc=%0d observed %h expected %h", i, cyc, wd[i], m_wd[i][cyc]);
        end
      end
    end
  endtask

  // One clock: offer the bundle to the selected instances, then check outputs.
  task automatic step(input logic [1:0] v);
    bit [1:0] acc;
    valid = v;
    for (int i = 0; i < 2; i++) acc[i] = v[i] && !m_stall[i][cyc];
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) if (acc[i]) schedule(i);
    @(negedge clk);
    valid = 2'b00;
    check_cycle();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    valid = 2'b00;
    repeat (n) begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        for (int k = cyc; k <= cyc + 1; k++) begin
          m_slot[i][k] = 1'b0; m_we[i][k] = 1'b0; m_stall[i][k] = 1'b0; m_busy[i][k] = 1'b0;
        end
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checks++;
        assert (we[i] === 1'b0 && rdy[i] === 1'b1 && busy[i] === 1'b0) else begin
          errors++;
          $error("FAIL reset_ctl[%0d] observed we=%b rdy=%b busy=%b expected we=0 rdy=1 busy=0",
                 i, we[i], rdy[i], busy[i]);
        end
        checks++;
        assert (wa[i] === 5'd0 && wd[i] === 32'd0) else begin
          errors++;
          $error("FAIL reset_data[%0d] observed wa=%0d wd=%h expected wa=0 wd=0", i, wa[i], wd[i]);
        end
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    valid = 2'b00;
    set_op(1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 1'b0, 64'd0);
    do_reset(2);

    // ALU result write, then an idle cycle.
    set_op(1'b1, 2'b00, 5'd3, 32'h0000_1234, 32'h0, 1'b0, 64'h0);
    step(2'b11);
    step(2'b00);

    // Status flag, both polarities.
    set_op(1'b1, 2'b10, 5'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0);
    step(2'b11);
    set_op(1'b1, 2'b10, 5'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'h0);
    step(2'b11);
    step(2'b00);

    // Product pair to R4/R5.
    set_op(1'b1, 2'b11, 5'd4, 32'h0, 32'h0, 1'b0, 64'hDEADBEEF_CAFEF00D);
    step(2'b11);
    step(2'b00);
    step(2'b00);

    // Pair on R31: high half wraps to R0 and is suppressed.
    set_op(1'b1, 2'b11, 5'd31, 32'h0, 32'h0, 1'b0, 64'h0123_4567_89AB_CDEF);
    step(2'b11);
    step(2'b00);
    step(2'b00);

    // Back-to-back loads, then a write to R0.
    for (int k = 1; k <= 3; k++) begin
      set_op(1'b1, 2'b01, 5'd10, 32'h0, 32'(k), 1'b0, 64'h0);
      step(2'b11);
    end
    set_op(1'b1, 2'b00, 5'd0, 32'h5555_AAAA, 32'h0, 1'b0, 64'h0);
    step(2'b11);
    step(2'b00);

    // Reset while the low half is showing: the high half never appears.
    set_op(1'b1, 2'b11, 5'd12, 32'h0, 32'h0, 1'b0, 64'h1111_2222_3333_4444);
    step(2'b11);
    do_reset(1);
    step(2'b00);

    // Reset while the high half is showing.
    set_op(1'b1, 2'b11, 5'd20, 32'h0, 32'h0, 1'b0, 64'h5555_6666_7777_8888);
    step(2'b11);
    step(2'b00);
    do_reset(1);
    step(2'b00);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        do_reset(1);
      end else begin
        set_op(1'($urandom_range(0, 3) != 0), 2'($urandom),
               ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom),
               $urandom, $urandom, 1'($urandom), {$urandom, $urandom});
        step(2'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
